spi_chain_arbiter: RTL and testbench
====================================

# spi_chain_arbiter

Round-robin transaction arbiter and sequencer that shares the single SPI master of the daisy-chain subsystem among several on-chip requesters. It accepts byte-transfer requests carrying data, mode and chip-select, and drives the master's data, mode, chip-select and load inputs. It times each transfer with an internal counter and returns a per-requester completion pulse. It sits directly in front of the SPI master inside the SPI top level.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- XFER_CYCLES, 40, clk cycles one master byte transfer occupies after load (>=1)
- GAP_CYCLES, 2, idle clk cycles enforced between transfers (>=0)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level
- req_data  in  NUM_REQ*8  requester i byte at [8i+7:8i]
- req_mode  in  NUM_REQ*2  requester i SPI mode at [2i+1:2i]
- req_cs  in  NUM_REQ*2  requester i chip-select code at [2i+1:2i]
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- data_m  out  8  byte to master
- mode_s  out  2  mode to master
- chip_selection  out  2  chip-select code to master
- load  out  1  one-cycle master start pulse
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, XFER, GAP.
- IDLE: if any req bit is high, select a winner, register its data/mode/cs into data_m/mode_s/chip_selection, load the counter with XFER_CYCLES-1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): load=1, gnt[winner]=1. Go to XFER.
- XFER: decrement the counter each cycle. At counter==0, go to GAP if GAP_CYCLES>0 (counter := GAP_CYCLES-1), else to IDLE. done[winner] is registered and goes high for the single cycle after the last XFER cycle.
- GAP: decrement. At 0, go to IDLE.
- Round-robin: a last-granted pointer resets to NUM_REQ-1, so requester 0 has first priority after reset. The search starts at pointer+1 and wraps. The pointer updates to the winner on entry to LOAD.
- Requester data is sampled only in the IDLE decision cycle. Later changes to req_data, req_mode or req_cs are ignored for that transfer.
- A requester must hold req until it sees gnt. Dropping req before the decision cycle withdraws the request. req high after gnt is a new request.
- data_m, mode_s and chip_selection hold their last values until the next grant.
- chip_selection is forwarded unchanged. Code 2'b01 selects no slave in the chain, but is still sequenced and completed normally.

## Timing
- Reset values: gnt=0, done=0, load=0, busy=0, data_m=0, mode_s=0, chip_selection=0, state IDLE, pointer=NUM_REQ-1.
- Reference timeline: req high in IDLE at cycle 0 → load and gnt at cycle 1 → done at cycle 2+XFER_CYCLES → IDLE at cycle 2+XFER_CYCLES+GAP_CYCLES.
- Earliest next load is at cycle 3+XFER_CYCLES+GAP_CYCLES.
- done can coincide with the first GAP cycle or with the IDLE decision cycle. The IDLE decision in that same cycle is allowed.
- Simultaneous requests: exactly one gnt per transfer. Losers wait, and no request is lost while req stays high.
- Reset asserted mid-transfer: all outputs clear immediately and asynchronously. No done pulse is ever issued for the aborted transfer.
- busy is combinational from state, high from LOAD through the last GAP cycle.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest-index active request always wins. The pointer is not implemented.
- SPI_ARB_FIXED_PRIO_EN not defined: round-robin as described above (default).

## Test plan
- Single request: XFER_CYCLES=40, GAP_CYCLES=2, req[2]=1 with data 8'hA5, mode 2'b01, cs 2'b11 at cycle 0 → load and gnt[2] at cycle 1 with data_m=8'hA5, mode_s=2'b01, chip_selection=2'b11; done[2] at cycle 42; busy low from cycle 44.
- Contention: req=4'b1111 held → grant order 0,1,2,3,0. With SPI_ARB_FIXED_PRIO_EN defined, requester 0 is granted repeatedly.
- Sampling: req_data[7:0] changed from 8'h3C to 8'hFF one cycle after gnt[0] → data_m stays 8'h3C until the next grant.
- Zero gap: GAP_CYCLES=0, req[1] held → done[1] and the IDLE decision occur in the same cycle, and the next load follows exactly one cycle later.
- Reset mid-XFER: rst driven low at counter=20 → outputs 0 immediately, no done pulse, and the next grant after release goes to requester 0.
- Withdrawn request: req[3] pulsed for one cycle while busy → no gnt[3], no done[3].

Source files
------------

// File: rtl/spi_chain_arbiter.sv
// spi_chain_arbiter: shares the single daisy-chain SPI master among NUM_REQ
// requesters. Each accepted request is registered into the master's
// data/mode/chip-select inputs, started with a one-cycle load pulse, timed
// with an internal counter, and acknowledged with a one-cycle done pulse.
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority; otherwise round-robin.
module spi_chain_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XFER_CYCLES = 40,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ*2-1:0] req_mode,
  input  logic [NUM_REQ*2-1:0] req_cs,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           data_m,
  output logic [1:0]           mode_s,
  output logic [1:0]           chip_selection,
  output logic                 load,
  output logic                 busy
);

  localparam int unsigned IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, XFER, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] winner;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          take;

`ifdef SPI_ARB_FIXED_PRIO_EN
  // Winner select: lowest active index; scanning downward lets it overwrite last.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = IW'(i - 1);
      if (req[idx]) sel = idx;
    end
  end
`else
  logic [IW-1:0] ptr;

  // Winner select: first active request after ptr, wrapping; scanning the
  // offsets downward leaves the nearest one (ptr+1) as the final overwrite.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = IW'((32'(ptr) + i) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and counter sequencing; take marks the IDLE decision cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          take      = 1'b1;
          cnt_nxt   = CW'(XFER_CYCLES - 1);
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = XFER;
      XFER: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = CW'(GAP_CYCLES - 1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counter, captured request fields, winner and registered done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      winner         <= '0;
      data_m         <= '0;
      mode_s         <= '0;
      chip_selection <= '0;
      done           <= '0;
    end else begin
      cnt  <= cnt_nxt;
      done <= '0;
      if (take) begin
        winner         <= sel;
        data_m         <= req_data[8*sel +: 8];
        mode_s         <= req_mode[2*sel +: 2];
        chip_selection <= req_cs[2*sel +: 2];
      end
      if (state == XFER && cnt == '0) done[winner] <= 1'b1;
    end
  end

`ifndef SPI_ARB_FIXED_PRIO_EN
  // Round-robin pointer follows the winner as the transfer is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ptr <= IW'(NUM_REQ - 1);
    else if (take) ptr <= sel;
  end
`endif

  // Grant, load and busy decode straight from state so reset clears them at once.
  always_comb begin
    gnt  = '0;
    load = (state == LOAD);
    busy = (state != IDLE);
    if (state == LOAD) gnt[winner] = 1'b1;
  end

endmodule

// File: tb/tb_spi_chain_arbiter.sv
// Directed bench for spi_chain_arbiter: a scoreboard queue holds the expected
// grant (requester, data, mode, cs) pushed as each request is raised and popped
// when the DUT grants. A second instance exercises the zero-gap case.
module tb_spi_chain_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_mode;
  logic [7:0]  req_cs;
  logic [3:0]  gnt, done;
  logic [7:0]  data_m;
  logic [1:0]  mode_s, chip_selection;
  logic        load, busy;

  logic [3:0]  z_req;
  logic [31:0] z_req_data;
  logic [7:0]  z_req_mode;
  logic [7:0]  z_req_cs;
  logic [3:0]  z_gnt, z_done;
  logic [7:0]  z_data_m;
  logic [1:0]  z_mode_s, z_chip_selection;
  logic        z_load, z_busy;

  always #5 clk = ~clk;

  spi_chain_arbiter #(.NUM_REQ(4), .XFER_CYCLES(40), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .req_cs(req_cs), .gnt(gnt), .done(done), .data_m(data_m), .mode_s(mode_s),
    .chip_selection(chip_selection), .load(load), .busy(busy)
  );

  spi_chain_arbiter #(.NUM_REQ(4), .XFER_CYCLES(5), .GAP_CYCLES(0)) u_dut_zg (
    .clk(clk), .rst(rst), .req(z_req), .req_data(z_req_data), .req_mode(z_req_mode),
    .req_cs(z_req_cs), .gnt(z_gnt), .done(z_done), .data_m(z_data_m), .mode_s(z_mode_s),
    .chip_selection(z_chip_selection), .load(z_load), .busy(z_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         r;
    logic [7:0] d;
    logic [1:0] m;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r);
    exp_t e;
    e.r = r;
    e.d = req_data[8*r +: 8];
    e.m = req_mode[2*r +: 2];
    e.c = req_cs[2*r +: 2];
    sb.push_back(e);
  endtask

  // Wait (bounded) for a grant and compare it with the oldest expectation.
  task automatic take_gnt(input string tag, output int n);
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 200);
    e = sb.pop_front();
    check({tag, "_gnt"},  32'(gnt),            1 << e.r);
    check({tag, "_load"}, 32'(load),           1);
    check({tag, "_data"}, 32'(data_m),         32'(e.d));
    check({tag, "_mode"}, 32'(mode_s),         32'(e.m));
    check({tag, "_cs"},   32'(chip_selection), 32'(e.c));
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_done, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0 && n < 200);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    int         n;
    int         cnt_a, cnt_b, cnt_c;
    int         r;
    logic [7:0] dexp;

    rst = 1'b1;
    req = '0; req_data = '0; req_mode = '0; req_cs = '0;
    z_req = '0; z_req_data = '0; z_req_mode = '0; z_req_cs = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_gnt",  32'(gnt),            0);
    check("rst_done", 32'(done),           0);
    check("rst_load", 32'(load),           0);
    check("rst_busy", 32'(busy),           0);
    check("rst_data", 32'(data_m),         0);
    check("rst_mode", 32'(mode_s),         0);
    check("rst_cs",   32'(chip_selection), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single request on requester 2.
    req[2] = 1'b1;
    req_data[23:16] = 8'hA5;
    req_mode[5:4]   = 2'b01;
    req_cs[5:4]     = 2'b11;
    push(2);
    take_gnt("single", n);
    check("single_lat", 32'(n), 1);
    req = '0;
    req_data[23:16] = 8'h00;
    @(negedge clk);
    check("single_load_off", 32'(load), 0);
    check("single_gnt_off",  32'(gnt),  0);
    check("single_busy",     32'(busy), 1);
    wait_done("single", 4'b0100, n);
    check("single_done_lat", 32'(n),      40);
    check("single_hold",     32'(data_m), 32'h0A5);
    @(negedge clk);
    check("single_gap_busy", 32'(busy), 1);
    @(negedge clk);
    check("single_idle", 32'(busy), 0);

    // Reset while the counter is at 20 aborts the transfer without done.
    req[0] = 1'b1;
    req_data[7:0] = 8'h5A;
    req_mode[1:0] = 2'b10;
    req_cs[1:0]   = 2'b00;
    push(0);
    take_gnt("rstmid", n);
    req = '0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy),   0);
    check("rstmid_load", 32'(load),   0);
    check("rstmid_gnt",  32'(gnt),    0);
    check("rstmid_data", 32'(data_m), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done != 4'b0) cnt_a++;
    end
    check("rstmid_no_done", 32'(cnt_a), 0);
    check("rstmid_idle",    32'(busy),  0);

    // Contention with all requests held; requester 0 data changes after its grant.
    req_data = {8'h44, 8'h33, 8'h22, 8'h3C};
    req_mode = 8'b11_10_01_00;
    req_cs   = 8'b00_01_10_11;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      r = 0;
`else
      r = k % 4;
`endif
      dexp = req_data[8*r +: 8];
      push(r);
      take_gnt($sformatf("cont%0d", k), n);
      if (k > 0) check($sformatf("cont%0d_gap", k), 32'(n), 3);
      if (k == 0) begin
        @(negedge clk);
        req_data[7:0] = 8'hFF;
      end
      if (k == 4) req = '0;
      wait_done($sformatf("cont%0d", k), 4'(1 << r), n);
      check($sformatf("cont%0d_hold", k), 32'(data_m), 32'(dexp));
    end
    repeat (3) @(negedge clk);

    // Withdrawn request: req[3] pulsed once while busy with a cs=01 transfer.
    req[1] = 1'b1;
    req_data[15:8] = 8'h77;
    req_mode[3:2]  = 2'b11;
    req_cs[3:2]    = 2'b01;
    push(1);
    take_gnt("cs01", n);
    req = '0;
    repeat (5) @(negedge clk);
    req[3] = 1'b1;
    @(negedge clk);
    req = '0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (gnt[3])  cnt_a++;
      if (done[3]) cnt_b++;
      if (done[1]) cnt_c++;
    end
    check("withdraw_gnt3",  32'(cnt_a), 0);
    check("withdraw_done3", 32'(cnt_b), 0);
    check("cs01_done1",     32'(cnt_c), 1);

    // Zero gap: done and the next IDLE decision share a cycle.
    z_req[1] = 1'b1;
    z_req_data[15:8] = 8'hC3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (z_gnt == 4'b0 && n < 50);
    check("zg_gnt",  32'(z_gnt),    32'h2);
    check("zg_data", 32'(z_data_m), 32'hC3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (z_done == 4'b0 && n < 50);
    check("zg_done",     32'(z_done), 32'h2);
    check("zg_done_lat", 32'(n),      6);
    check("zg_idle",     32'(z_busy), 0);
    @(negedge clk);
    check("zg_reload", 32'(z_load), 1);
    check("zg_regnt",  32'(z_gnt),  32'h2);
    z_req = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
